// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback slice: default widths,
// requester indices and the rotation order used by the round-robin build.
package rf_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int NUM_REQ        = 3;

  // Writeback requesters; the numeric order is also the rotation order
  // ALU -> LSU -> MDU -> ALU.
  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_LSU = 2'd1,
    REQ_MDU = 2'd2
  } req_idx_t;

  // Next requester in the rotation ring.
  function automatic req_idx_t next_req(input req_idx_t cur);
    req_idx_t nxt;
    case (cur)
      REQ_ALU: nxt = REQ_LSU;
      REQ_LSU: nxt = REQ_MDU;
      default: nxt = REQ_ALU;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the execution units and the arbiter.
// Handshake: a unit raises <unit>_valid with rd/data and holds all three
// stable until a rising edge where <unit>_valid && <unit>_ready is seen;
// that edge completes the transfer. ready is never high without valid.
// The rf_* group is the register-file write port (no back-pressure).
// busy is the scoreboard state, exported for observation.
interface rf_wb_arbiter_if
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                       alu_valid;
  logic                       alu_ready;
  logic [ADDR_WIDTH-1:0]      alu_rd;
  logic [DATA_WIDTH-1:0]      alu_data;

  logic                       lsu_valid;
  logic                       lsu_ready;
  logic [ADDR_WIDTH-1:0]      lsu_rd;
  logic [DATA_WIDTH-1:0]      lsu_data;

  logic                       mdu_valid;
  logic                       mdu_ready;
  logic [ADDR_WIDTH-1:0]      mdu_rd;
  logic [DATA_WIDTH-1:0]      mdu_data;

  logic                       rf_wen;
  logic [ADDR_WIDTH-1:0]      rf_waddr;
  logic [DATA_WIDTH-1:0]      rf_wdata;

  logic                       issue_en;
  logic [ADDR_WIDTH-1:0]      issue_rd;

  logic [ADDR_WIDTH-1:0]      chk_rs1;
  logic [ADDR_WIDTH-1:0]      chk_rs2;
  logic                       chk_busy;

  logic [2**ADDR_WIDTH-1:0]   busy;

  // Execution-unit / issue side.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output mdu_valid, mdu_rd, mdu_data,
    output issue_en, issue_rd, chk_rs1, chk_rs2,
    input  alu_ready, lsu_ready, mdu_ready,
    input  rf_wen, rf_waddr, rf_wdata, chk_busy, busy
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  mdu_valid, mdu_rd, mdu_data,
    input  issue_en, issue_rd, chk_rs1, chk_rs2,
    output alu_ready, lsu_ready, mdu_ready,
    output rf_wen, rf_waddr, rf_wdata, chk_busy, busy
  );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Per-register pending-write scoreboard. A bit is set when an instruction
// writing that register issues and cleared when its write commits; a set
// and a clear of the same register in one cycle leaves the bit set, since
// the newer producer is still outstanding. Register 0 is never busy.
module rf_scoreboard #(
  parameter int ADDR_WIDTH = rf_ctrl_pkg::DEF_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [ADDR_WIDTH-1:0]    set_idx,
  input  logic                     clr_en,
  input  logic [ADDR_WIDTH-1:0]    clr_idx,
  input  logic [ADDR_WIDTH-1:0]    rs1,
  input  logic [ADDR_WIDTH-1:0]    rs2,
  output logic                     busy_out,
  output logic [2**ADDR_WIDTH-1:0] busy_vec
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy state: clear the committed register first, then let a new
  // issue win over it.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_idx] = 1'b0;
    end
    if (set_en && (set_idx != '0)) begin
      busy_d[set_idx] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy bit storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Source-operand hazard check against the current (pre-edge) state.
  always_comb begin
    busy_out = ((rs1 != '0) && busy_q[rs1]) || ((rs2 != '0) && busy_q[rs2]);
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: picks one of ALU/LSU/MDU per cycle, registers the
// winning rd/data onto the register-file write port one cycle later and
// keeps the pending-write scoreboard up to date.
// Default build: fixed priority LSU > MDU > ALU.
// Define RF_WB_ROUND_ROBIN_EN for rotating priority (last winner goes last).
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  rf_wb_arbiter_if.slave wb
);

  req_idx_t              prio [NUM_REQ];
  logic                  gnt_any;
  req_idx_t              gnt_idx;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Valid of one requester selected by index.
  function automatic logic valid_of(input req_idx_t r, input logic v_alu,
                                    input logic v_lsu, input logic v_mdu);
    logic v;
    case (r)
      REQ_LSU: v = v_lsu;
      REQ_MDU: v = v_mdu;
      default: v = v_alu;
    endcase
    return v;
  endfunction

`ifdef RF_WB_ROUND_ROBIN_EN
  // Last granted unit; it becomes lowest priority for the next decision.
  req_idx_t rr_ptr;

  // Priority list starts just after the last winner.
  always_comb begin
    prio[0] = next_req(rr_ptr);
    prio[1] = next_req(prio[0]);
    prio[2] = next_req(prio[1]);
  end

  // Pointer follows grants and holds on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= REQ_ALU;
    end else if (gnt_any) begin
      rr_ptr <= gnt_idx;
    end
  end
`else
  // Fixed priority list.
  always_comb begin
    prio[0] = REQ_LSU;
    prio[1] = REQ_MDU;
    prio[2] = REQ_ALU;
  end
`endif

  // First valid requester in priority order wins; nothing is granted in reset.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = REQ_ALU;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_any && valid_of(prio[i], wb.alu_valid, wb.lsu_valid, wb.mdu_valid)) begin
          gnt_any = 1'b1;
          gnt_idx = prio[i];
        end
      end
    end
  end

  // Ready is the grant itself, so the transfer completes this cycle.
  always_comb begin
    wb.alu_ready = gnt_any && (gnt_idx == REQ_ALU);
    wb.lsu_ready = gnt_any && (gnt_idx == REQ_LSU);
    wb.mdu_ready = gnt_any && (gnt_idx == REQ_MDU);
  end

  // Route the winner's payload to the output register.
  always_comb begin
    case (gnt_idx)
      REQ_LSU: begin
        sel_rd   = wb.lsu_rd;
        sel_data = wb.lsu_data;
      end
      REQ_MDU: begin
        sel_rd   = wb.mdu_rd;
        sel_data = wb.mdu_data;
      end
      default: begin
        sel_rd   = wb.alu_rd;
        sel_data = wb.alu_data;
      end
    endcase
  end

  // Output stage: one write per accepted request, never stalls. Writes to
  // register 0 are accepted but suppressed on the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= gnt_any && (sel_rd != '0);
      if (gnt_any) begin
        waddr_q <= sel_rd;
        wdata_q <= sel_data;
      end
    end
  end

  assign wb.rf_wen   = wen_q;
  assign wb.rf_waddr = waddr_q;
  assign wb.rf_wdata = wdata_q;

  // Scoreboard: set on issue, clear when the write port commits.
  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (wb.issue_en),
    .set_idx  (wb.issue_rd),
    .clr_en   (wen_q),
    .clr_idx  (waddr_q),
    .rs1      (wb.chk_rs1),
    .rs2      (wb.chk_rs2),
    .busy_out (wb.chk_busy),
    .busy_vec (wb.busy)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model (priority list, write
// queue, busy array).
module tb_rf_wb_arbiter;
  import rf_ctrl_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 2**AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wb ();

  rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  // ---------------- stimulus state ----------------
  bit              v_in  [3];   // index 0 ALU, 1 LSU, 2 MDU
  logic [AW-1:0]   rd_in [3];
  logic [DW-1:0]   d_in  [3];
  bit              iss_en;
  logic [AW-1:0]   iss_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;

  // ---------------- model / scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];   // {rd, data} due on the write port next cycle
  bit               busy_m [NREG];
  int               ptr_m;      // last granted unit
  int               last_gnt;
  logic [2:0]       obs_rdy;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    wb.alu_valid = v_in[0]; wb.alu_rd = rd_in[0]; wb.alu_data = d_in[0];
    wb.lsu_valid = v_in[1]; wb.lsu_rd = rd_in[1]; wb.lsu_data = d_in[1];
    wb.mdu_valid = v_in[2]; wb.mdu_rd = rd_in[2]; wb.mdu_data = d_in[2];
    wb.issue_en  = iss_en;
    wb.issue_rd  = iss_rd;
    wb.chk_rs1   = rs1;
    wb.chk_rs2   = rs2;
  endtask

  task automatic clear_inputs();
    for (int u = 0; u < 3; u++) begin
      v_in[u] = 0; rd_in[u] = '0; d_in[u] = '0;
    end
    iss_en = 0; iss_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  function automatic void model_reset();
    exp_q.delete();
    for (int i = 0; i < NREG; i++) busy_m[i] = 0;
    ptr_m    = 0;
    last_gnt = -1;
  endfunction

  // Which unit the policy should pick this cycle, -1 if none.
  function automatic int model_grant();
    int order [3];
`ifdef RF_WB_ROUND_ROBIN_EN
    for (int i = 0; i < 3; i++) order[i] = (ptr_m + 1 + i) % 3;
`else
    order[0] = 1; order[1] = 2; order[2] = 0;
`endif
    if (rst) return -1;
    for (int i = 0; i < 3; i++) begin
      if (v_in[order[i]]) return order[i];
    end
    return -1;
  endfunction

  // One clock: drive, check at negedge, advance model at posedge.
  task automatic step();
    int               g;
    bit               exp_wen;
    logic [AW+DW-1:0] e;
    logic [AW-1:0]    exp_wa;
    logic [NREG-1:0]  bv;
    bit               exp_chk;
    drive();
    @(negedge clk);
    exp_wen = (exp_q.size() > 0);
    exp_wa  = '0;
    check_val("rf_wen", {63'd0, wb.rf_wen}, {63'd0, exp_wen});
    if (exp_wen) begin
      e      = exp_q.pop_front();
      exp_wa = e[AW+DW-1:DW];
      check_val("rf_waddr", {59'd0, wb.rf_waddr}, {59'd0, exp_wa});
      check_val("rf_wdata", {32'd0, wb.rf_wdata}, {32'd0, e[DW-1:0]});
    end
    for (int i = 0; i < NREG; i++) bv[i] = busy_m[i];
    check_val("busy_vec", {32'd0, wb.busy}, {32'd0, bv});
    exp_chk = ((rs1 != 0) && busy_m[rs1]) || ((rs2 != 0) && busy_m[rs2]);
    check_val("chk_busy", {63'd0, wb.chk_busy}, {63'd0, exp_chk});
    g       = model_grant();
    obs_rdy = {wb.mdu_ready, wb.lsu_ready, wb.alu_ready};
    check_val("ready", {61'd0, obs_rdy}, (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0 && rd_in[g] != 0) exp_q.push_back({rd_in[g], d_in[g]});
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (exp_wen) busy_m[exp_wa] = 0;
      if (iss_en && iss_rd != 0) busy_m[iss_rd] = 1;
      if (g >= 0) ptr_m = g;
      last_gnt = g;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int cnt [3];
  logic [2:0] prev_rdy;

  initial begin
    clear_inputs();
    for (int u = 0; u < 3; u++) v_in[u] = 1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", {61'd0, wb.mdu_ready, wb.lsu_ready, wb.alu_ready}, 64'd0);
    check_val("rst_wen",   {63'd0, wb.rf_wen}, 64'd0);
    check_val("rst_waddr", {59'd0, wb.rf_waddr}, 64'd0);
    check_val("rst_wdata", {32'd0, wb.rf_wdata}, 64'd0);
    check_val("rst_busy",  {32'd0, wb.busy}, 64'd0);
    rst = 1'b0;
    clear_inputs();
    model_reset();

    // Single ALU write.
    v_in[0] = 1; rd_in[0] = 5; d_in[0] = 32'h1234;
    step();
    check_val("t028_alu_ready", {63'd0, obs_rdy[0]}, 64'd1);
    v_in[0] = 0;
    check_val("t028_wen",   {63'd0, wb.rf_wen}, 64'd1);
    check_val("t028_waddr", {59'd0, wb.rf_waddr}, 64'd5);
    check_val("t028_wdata", {32'd0, wb.rf_wdata}, 64'h1234);
    step();

    // Scoreboard set / commit / same-cycle reissue.
    iss_en = 1; iss_rd = 7; rs1 = 7;
    step();
    iss_en = 0;
    check_val("t031_set", {63'd0, wb.chk_busy}, 64'd1);
    v_in[0] = 1; rd_in[0] = 7; d_in[0] = $urandom;
    step();
    v_in[0] = 0;
    check_val("t031_commit_cycle", {63'd0, wb.chk_busy}, 64'd1);
    iss_en = 1; iss_rd = 7;
    step();
    iss_en = 0;
    check_val("t031_reissue", {63'd0, wb.chk_busy}, 64'd1);
    v_in[0] = 1; rd_in[0] = 7; d_in[0] = $urandom;
    step();
    v_in[0] = 0;
    step();
    check_val("t031_cleared", {63'd0, wb.chk_busy}, 64'd0);

    // Write to register 0.
    v_in[1] = 1; rd_in[1] = 0; d_in[1] = $urandom; rs1 = 0; rs2 = 0;
    iss_en = 1; iss_rd = 0;
    step();
    check_val("t032_lsu_ready", {63'd0, obs_rdy[1]}, 64'd1);
    v_in[1] = 0; iss_en = 0;
    check_val("t032_wen", {63'd0, wb.rf_wen}, 64'd0);
    check_val("t032_chk", {63'd0, wb.chk_busy}, 64'd0);
    step();

    // All three valid after reset: LSU, MDU, ALU.
    do_reset();
    for (int u = 0; u < 3; u++) begin
      v_in[u] = 1; d_in[u] = $urandom;
    end
    rd_in[0] = 1; rd_in[1] = 2; rd_in[2] = 3;
    step();
    check_val("t029_g0", {61'd0, obs_rdy}, 64'b010);
    check_val("t029_w0", {63'd0, wb.rf_wen}, 64'd1);
    v_in[1] = 0;
    step();
    check_val("t029_g1", {61'd0, obs_rdy}, 64'b100);
    check_val("t029_w1", {63'd0, wb.rf_wen}, 64'd1);
    v_in[2] = 0;
    step();
    check_val("t029_g2", {61'd0, obs_rdy}, 64'b001);
    check_val("t029_w2", {63'd0, wb.rf_wen}, 64'd1);
    v_in[0] = 0;
    step();

`ifdef RF_WB_ROUND_ROBIN_EN
    // Continuous requests under rotation.
    do_reset();
    for (int u = 0; u < 3; u++) begin
      v_in[u] = 1; rd_in[u] = AW'(u + 1); d_in[u] = $urandom; cnt[u] = 0;
    end
    prev_rdy = 3'b000;
    for (int c = 0; c < 6; c++) begin
      step();
      for (int u = 0; u < 3; u++) if (obs_rdy[u]) begin
        cnt[u]++;
        d_in[u] = $urandom;
      end
      check_val("t030_no_repeat", {63'd0, (obs_rdy == prev_rdy)}, 64'd0);
      prev_rdy = obs_rdy;
    end
    for (int u = 0; u < 3; u++) check_val("t030_count", cnt[u], 64'd2);
    clear_inputs();
    step();
`endif

    // Reset right after an accepted MDU write.
    v_in[2] = 1; rd_in[2] = 9; d_in[2] = $urandom; iss_en = 1; iss_rd = 9;
    step();
    v_in[2] = 0; iss_en = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t033_wen",   {63'd0, wb.rf_wen}, 64'd0);
    check_val("t033_busy9", {63'd0, wb.busy[9]}, 64'd0);
    step();

    // Random traffic with one mid-run reset.
    clear_inputs();
    for (int c = 0; c < 500; c++) begin
      for (int u = 0; u < 3; u++) begin
        if (last_gnt == u) v_in[u] = 0;
        if (!v_in[u] && $urandom_range(0, 99) < 60) begin
          v_in[u]  = 1;
          rd_in[u] = AW'($urandom_range(0, 7));
          d_in[u]  = $urandom;
        end
      end
      iss_en = bit'($urandom_range(0, 1));
      iss_rd = AW'($urandom_range(0, 7));
      rs1    = AW'($urandom_range(0, 7));
      rs2    = AW'($urandom_range(0, 7));
      rst    = (c == 250);
      step();
    end
    rst = 1'b0;
    clear_inputs();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, register index width; 2**ADDR_WIDTH registers are tracked.
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have ports {alu,lsu,mdu}_valid  input  1 each  writeback request from that unit.
REQ-006 The block SHALL have ports {alu,lsu,mdu}_ready  output  1 each  request accepted this cycle.
REQ-007 The block SHALL have ports {alu,lsu,mdu}_rd  input  ADDR_WIDTH each  destination register.
REQ-008 The block SHALL have ports {alu,lsu,mdu}_data  input  DATA_WIDTH each  writeback data.
REQ-009 The block SHALL have ports rf_wen  output  1,  rf_waddr  output  ADDR_WIDTH,  rf_wdata  output  DATA_WIDTH  driving the register file write port.
REQ-010 The block SHALL have ports issue_en  input  1  and  issue_rd  input  ADDR_WIDTH  marking a destination register pending at issue.
REQ-011 The block SHALL have ports chk_rs1, chk_rs2  input  ADDR_WIDTH each  and  chk_busy  output  1  for the source-operand hazard check.

Function
REQ-012 The arbiter SHALL grant at most one requester per cycle; ready is combinational, equal to the grant, and asserted only with that unit's valid.
REQ-013 Default policy SHALL be fixed priority LSU > MDU > ALU.
REQ-014 A transfer SHALL complete on a rising edge with valid && ready; requesters hold valid/rd/data stable until then.
REQ-015 The accepted rd/data SHALL be registered and appear on rf_waddr/rf_wdata with rf_wen=1 exactly one cycle after acceptance; otherwise rf_wen=0.
REQ-016 The output stage SHALL never back-pressure: one write per cycle is sustained, and an idle cycle occurs only when no valid is high.
REQ-017 A request with rd==0 SHALL be accepted normally but SHALL produce rf_wen=0.
REQ-018 The scoreboard SHALL hold one busy bit per register; issue_en with issue_rd!=0 sets busy[issue_rd] at the edge.
REQ-019 busy[rf_waddr] SHALL clear at the edge where rf_wen=1 (write committed); a set and clear of the same register in one cycle SHALL leave the bit set.
REQ-020 chk_busy SHALL be combinational: (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]); register 0 is never busy.
REQ-021 Writeback to a register whose busy bit is already clear SHALL still be performed; busy stays clear.

Reset
REQ-022 While rst=1 at an edge: rf_wen=0, rf_waddr=0, rf_wdata=0, all busy bits=0, round-robin pointer=ALU; ready outputs SHALL be 0 during rst.
REQ-023 An accepted-but-uncommitted write at reset SHALL be discarded (rf_wen=0 in the cycle after reset).

Configuration
REQ-024 With macro RF_WB_ROUND_ROBIN_EN defined, priority SHALL rotate: after a grant to unit k, unit k becomes lowest priority (order ALU->LSU->MDU->ALU); the pointer is unchanged on idle cycles.
REQ-025 Without RF_WB_ROUND_ROBIN_EN, fixed priority per REQ-013 SHALL apply and no pointer state exists.

Structure
REQ-026 Package rf_ctrl_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults and the requester index enum (REQ_ALU, REQ_LSU, REQ_MDU).
REQ-027 Scoreboard SHALL be sub-module rf_scoreboard (set/clear/check); arbitration and output register are in the top.

Verification
REQ-028 Single ALU valid, rd=5, data=0x1234 -> alu_ready=1 same cycle; rf_wen=1, waddr=5, wdata=0x1234 next cycle.
REQ-029 All three valid (rd 1/2/3), fixed priority -> grant order LSU, MDU, ALU over three cycles, rf_wen high three consecutive cycles.
REQ-030 RF_WB_ROUND_ROBIN_EN, all three valid continuously for 6 cycles -> each unit granted exactly twice, never twice in a row.
REQ-031 issue_en rd=7, chk_rs1=7 -> chk_busy=1 until the cycle after rf_wen with waddr=7; same-cycle reissue of rd=7 keeps chk_busy=1.
REQ-032 LSU valid rd=0 -> lsu_ready=1, rf_wen stays 0; chk_rs1=0 -> chk_busy=0.
REQ-033 Accept MDU write rd=9, assert rst next cycle -> rf_wen=0, busy[9]=0 after reset.
